// File: rtl/sp_ram_arb_pkg.sv
// Shared types for the two-port sp_ram arbiter: port identifiers and the request payload.
// The payload struct fixes the address/data widths that the arbiter instances must use.
package sp_ram_arb_pkg;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  localparam int NUM_PORTS      = 2;
  localparam int ARB_ADDR_WIDTH = 15;
  localparam int ARB_DATA_WIDTH = 32;
  localparam int ARB_BE_WIDTH   = ARB_DATA_WIDTH / 8;

  typedef struct packed {
    logic [ARB_ADDR_WIDTH-1:0] addr;
    logic                      we;
    logic [ARB_BE_WIDTH-1:0]   be;
    logic [ARB_DATA_WIDTH-1:0] wdata;
  } req_t;

  // P1 wins only when its grant bit is set; the grant vector is one-hot or zero.
  function automatic port_e onehot_to_port(input logic [NUM_PORTS-1:0] g);
    return g[1] ? PORT1 : PORT0;
  endfunction

endpackage

// File: rtl/sp_ram_arb_prio.sv
// Conflict resolution for the sp_ram arbiter; produces a one-hot grant vector.
// Define SP_RAM_ARB_RR_EN for round-robin; otherwise fixed priority with P1 starvation guard.
module sp_ram_arb_prio
  import sp_ram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] gnt
);

`ifdef SP_RAM_ARB_RR_EN

  port_e last_q;

  always_comb begin
    gnt = '0;
    if (req[0] && req[1]) begin
      if (last_q == PORT1) gnt[0] = 1'b1;
      else                 gnt[1] = 1'b1;
    end else begin
      gnt = req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= PORT1;
    end else if (|gnt) begin
      last_q <= onehot_to_port(gnt);
    end
  end

`else

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_q;
  logic          force_p1;

  // A limit of zero means P1 is never forced through.
  assign force_p1 = (STARVE_LIMIT != 0) && (starve_q == LIMIT);

  always_comb begin
    gnt = '0;
    if (req[0] && req[1]) begin
      if (force_p1) gnt[1] = 1'b1;
      else          gnt[0] = 1'b1;
    end else begin
      gnt = req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (req[1] && !gnt[1]) begin
      if (starve_q != LIMIT) starve_q <= starve_q + 1'b1;
    end else begin
      starve_q <= '0;
    end
  end

`endif

endmodule

// File: rtl/sp_ram_arbiter.sv
// Shares one single-port RAM between P0 (core LSU) and P1 (AXI/debug bridge), routing rdata to the owner.
// Define SP_RAM_ARB_RR_EN for round-robin conflict resolution instead of fixed priority.
module sp_ram_arbiter
  import sp_ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = ARB_ADDR_WIDTH,
  parameter int DATA_WIDTH   = ARB_DATA_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    p0_req_i,
  input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
  input  logic                    p0_we_i,
  input  logic [DATA_WIDTH/8-1:0] p0_be_i,
  input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
  output logic                    p0_gnt_o,
  output logic                    p0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p0_rdata_o,

  input  logic                    p1_req_i,
  input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
  input  logic                    p1_we_i,
  input  logic [DATA_WIDTH/8-1:0] p1_be_i,
  input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
  output logic                    p1_gnt_o,
  output logic                    p1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p1_rdata_o,

  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] gnt;
  req_t                 p0_pay;
  req_t                 p1_pay;
  req_t                 sel;
  port_e                owner_q;
  logic                 valid_q;
  logic                 read_q;

  // Requests are masked while reset is asserted so no grant leaks out combinationally.
  assign req = {p1_req_i, p0_req_i} & {NUM_PORTS{rst_n}};

  sp_ram_arb_prio #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt)
  );

  assign p0_gnt_o = gnt[0];
  assign p1_gnt_o = gnt[1];

  always_comb begin
    p0_pay = '{addr: p0_addr_i, we: p0_we_i, be: p0_be_i, wdata: p0_wdata_i};
    p1_pay = '{addr: p1_addr_i, we: p1_we_i, be: p1_be_i, wdata: p1_wdata_i};
  end

  // With no grant the mux falls back to P0, but enables are forced low.
  assign sel         = gnt[1] ? p1_pay : p0_pay;
  assign ram_en_o    = |gnt;
  assign ram_addr_o  = sel.addr;
  assign ram_we_o    = ram_en_o & sel.we;
  assign ram_be_o    = ram_en_o ? sel.be : '0;
  assign ram_wdata_o = sel.wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      owner_q <= PORT0;
      read_q  <= 1'b0;
    end else begin
      valid_q <= |gnt;
      if (|gnt) begin
        owner_q <= onehot_to_port(gnt);
        read_q  <= ~sel.we;
      end
    end
  end

  // Write responses carry zero data; only reads expose the RAM output.
  assign p0_rvalid_o = valid_q & (owner_q == PORT0);
  assign p1_rvalid_o = valid_q & (owner_q == PORT1);
  assign p0_rdata_o  = (p0_rvalid_o && read_q) ? ram_rdata_i : '0;
  assign p1_rdata_o  = (p1_rvalid_o && read_q) ? ram_rdata_i : '0;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Scoreboard bench for sp_ram_arbiter with a behavioural 1-cycle-latency RAM behind it.
// Define SP_RAM_ARB_RR_EN to check the round-robin conflict sequence instead of fixed priority.
module tb_sp_ram_arbiter;

  localparam int AW = 15;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk;
  logic          rst_n;
  logic          p0_req, p0_we, p0_gnt, p0_rvalid;
  logic [AW-1:0] p0_addr;
  logic [BW-1:0] p0_be;
  logic [DW-1:0] p0_wdata, p0_rdata;
  logic          p1_req, p1_we, p1_gnt, p1_rvalid;
  logic [AW-1:0] p1_addr;
  logic [BW-1:0] p1_be;
  logic [DW-1:0] p1_wdata, p1_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [BW-1:0] ram_be;
  logic [DW-1:0] ram_wdata, ram_rdata;

  sp_ram_arbiter #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .STARVE_LIMIT (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .p0_req_i    (p0_req),
    .p0_addr_i   (p0_addr),
    .p0_we_i     (p0_we),
    .p0_be_i     (p0_be),
    .p0_wdata_i  (p0_wdata),
    .p0_gnt_o    (p0_gnt),
    .p0_rvalid_o (p0_rvalid),
    .p0_rdata_o  (p0_rdata),
    .p1_req_i    (p1_req),
    .p1_addr_i   (p1_addr),
    .p1_we_i     (p1_we),
    .p1_be_i     (p1_be),
    .p1_wdata_i  (p1_wdata),
    .p1_gnt_o    (p1_gnt),
    .p1_rvalid_o (p1_rvalid),
    .p1_rdata_o  (p1_rdata),
    .ram_en_o    (ram_en),
    .ram_addr_o  (ram_addr),
    .ram_we_o    (ram_we),
    .ram_be_o    (ram_be),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM, word addressed by the byte address.
  logic [DW-1:0] mem [0:8191];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < BW; b++)
          if (ram_be[b]) mem[ram_addr[14:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= mem[ram_addr[14:2]];
      end
    end
  end

  typedef struct {
    logic [1:0]    route;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t       rsp_q[$];
  logic [1:0] gnt_q[$];
  int         total = 0;
  int         bad   = 0;

  task automatic check_output(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT shows a grant or a response.
  initial begin
    rsp_t       r;
    logic [1:0] g;
    forever begin
      @(negedge clk);
      if (p0_gnt || p1_gnt) begin
        if (gnt_q.size() == 0) begin
          check_output("unexpected_gnt", {30'b0, p1_gnt, p0_gnt}, 32'h0);
        end else begin
          g = gnt_q.pop_front();
          check_output("gnt", {30'b0, p1_gnt, p0_gnt}, {30'b0, g});
        end
      end
      if (p0_rvalid || p1_rvalid) begin
        if (rsp_q.size() == 0) begin
          check_output("stray_rvalid", {30'b0, p1_rvalid, p0_rvalid}, 32'h0);
        end else begin
          r = rsp_q.pop_front();
          check_output("rvalid_route", {30'b0, p1_rvalid, p0_rvalid}, {30'b0, r.route});
          check_output("rdata", p1_rvalid ? p1_rdata : p0_rdata, r.data);
          check_output("other_rdata_zero", p1_rvalid ? p0_rdata : p1_rdata, 32'h0);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input int port, input logic we, input logic [AW-1:0] addr,
                                input logic [BW-1:0] be, input logic [DW-1:0] wdata,
                                input logic [DW-1:0] exp_rdata);
    p0_req = 1'b0;
    p1_req = 1'b0;
    if (port == 0) begin
      p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_be = be; p0_wdata = wdata;
    end else begin
      p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_be = be; p1_wdata = wdata;
    end
    gnt_q.push_back((port == 0) ? 2'b01 : 2'b10);
    rsp_q.push_back('{route: (port == 0) ? 2'b01 : 2'b10, data: we ? 32'h0 : exp_rdata});
    tick(1);
    p0_req = 1'b0;
    p1_req = 1'b0;
  endtask

  logic [1:0] seq [10];

  initial begin
    rst_n = 1'b0;
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = '0; p0_be = 4'hF; p0_wdata = '0;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = '0; p1_be = 4'hF; p1_wdata = '0;

    // Reset state with both requests held: everything must stay quiet.
    tick(2);
    check_output("rst_gnt",    {30'b0, p1_gnt, p0_gnt},       32'h0);
    check_output("rst_rvalid", {30'b0, p1_rvalid, p0_rvalid}, 32'h0);
    check_output("rst_rdata",  p0_rdata | p1_rdata,           32'h0);
    check_output("rst_ram",    {26'b0, ram_be, ram_we, ram_en}, 32'h0);
    p0_req = 1'b0;
    p1_req = 1'b0;
    rst_n  = 1'b1;
    tick(2);

    // P0 alone: write then read back.
    apply_stimulus(0, 1'b1, 15'h0004, 4'hF, 32'hDEADBEEF, 32'h0);
    apply_stimulus(0, 1'b0, 15'h0004, 4'hF, 32'h0,        32'hDEADBEEF);
    apply_stimulus(0, 1'b1, 15'h0000, 4'hF, 32'hCAFEF00D, 32'h0);
    tick(2);

    // Row routing, back-to-back alternating owners.
    apply_stimulus(1, 1'b1, 15'h6000, 4'hF, 32'h11223344, 32'h0);
    apply_stimulus(0, 1'b0, 15'h0000, 4'hF, 32'h0,        32'hCAFEF00D);
    apply_stimulus(1, 1'b0, 15'h6000, 4'hF, 32'h0,        32'h11223344);
    apply_stimulus(0, 1'b0, 15'h0004, 4'hF, 32'h0,        32'hDEADBEEF);
    tick(2);

    // Byte-lane write merge, then P0 reads the same word next cycle.
    apply_stimulus(1, 1'b1, 15'h2008, 4'hF,    32'hFFFFFFFF, 32'h0);
    apply_stimulus(1, 1'b1, 15'h2008, 4'b0100, 32'h00AB0000, 32'h0);
    apply_stimulus(1, 1'b0, 15'h2008, 4'hF,    32'h0,        32'hFFABFFFF);
    apply_stimulus(0, 1'b0, 15'h2008, 4'hF,    32'h0,        32'hFFABFFFF);
    tick(2);

    // Idle with a write payload parked on P0: RAM controls must stay low.
    p0_we = 1'b1; p0_be = 4'hF;
    #1;
    check_output("idle_ram", {26'b0, ram_be, ram_we, ram_en}, 32'h0);

    // Reset arriving after a grant drops the pending response.
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 15'h0004;
    gnt_q.push_back(2'b01);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("midrst_gnt", {30'b0, p1_gnt, p0_gnt, ram_en}, 32'h0);
    tick(1);
    check_output("midrst_rvalid", {30'b0, p1_rvalid, p0_rvalid}, 32'h0);
    p0_req = 1'b0;
    rst_n  = 1'b1;
    tick(3);

    // Conflict: fresh reset so priority state starts from its reset value.
`ifdef SP_RAM_ARB_RR_EN
    for (int i = 0; i < 10; i++) seq[i] = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
    for (int i = 0; i < 10; i++) seq[i] = (i == 4 || i == 9) ? 2'b10 : 2'b01;
`endif
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 15'h0004;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 15'h6000;
    for (int i = 0; i < 10; i++) begin
      gnt_q.push_back(seq[i]);
      rsp_q.push_back('{route: seq[i], data: (seq[i] == 2'b01) ? 32'hDEADBEEF : 32'h11223344});
      tick(1);
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick(4);

    check_output("gnt_queue_left", gnt_q.size(), 32'h0);
    check_output("rsp_queue_left", rsp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
